// File: rtl/esc_array_if.sv
// Flight-controller to ESC-array bus: packed speed commands, strobes and the PWM/status returns.
interface esc_array_if #(
    parameter int unsigned NUM_MOTORS = 4,
    parameter int unsigned SPD_W      = 11
);
    logic [NUM_MOTORS*SPD_W-1:0] spd;
    logic                        wrt;
    logic                        motors_off;
    logic [NUM_MOTORS-1:0]       pwm;
    logic                        stale;
    logic                        frame_strt;

    modport master (
        output spd, wrt, motors_off,
        input  pwm, stale, frame_strt
    );

    modport slave (
        input  spd, wrt, motors_off,
        output pwm, stale, frame_strt
    );
endinterface

// File: rtl/esc_array.sv
// N-channel ESC PWM generator: frame-aligned double-buffered speeds, saturation, command watchdog.
// Optional build macro ESC_RAMP_EN limits the per-frame speed change to RAMP_STEP.
module esc_array #(
    parameter int unsigned NUM_MOTORS     = 4,
    parameter int unsigned SPD_W          = 11,
    parameter int unsigned PERIOD         = 125000,
    parameter int unsigned MIN_PULSE      = 50000,
    parameter int unsigned SCALE          = 24,
    parameter int unsigned MAX_SPD        = 2047,
    parameter int unsigned TIMEOUT_FRAMES = 8,
    parameter int unsigned RAMP_STEP      = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    esc_array_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(PERIOD);
    localparam int unsigned WD_W  = $clog2(TIMEOUT_FRAMES + 1);

    if (MIN_PULSE + MAX_SPD * SCALE >= PERIOD) begin : g_bad_timing
        $error("esc_array: MIN_PULSE + MAX_SPD*SCALE must be below PERIOD");
    end
    if (RAMP_STEP == 0) begin : g_bad_ramp
        $error("esc_array: RAMP_STEP must be nonzero");
    end

    typedef enum logic {RUN, FAILSAFE} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [WD_W-1:0]       wd_q, wd_d;
    logic                  pending_q, pending_d;
    logic [SPD_W-1:0]      shadow_q [NUM_MOTORS];
    logic [SPD_W-1:0]      shadow_d [NUM_MOTORS];
    logic [SPD_W-1:0]      active_q [NUM_MOTORS];
    logic [SPD_W-1:0]      active_d [NUM_MOTORS];
    logic [SPD_W-1:0]      sat      [NUM_MOTORS];
    logic [SPD_W-1:0]      tgt      [NUM_MOTORS];
    logic [CNT_W-1:0]      thr_q    [NUM_MOTORS];
    logic [CNT_W-1:0]      thr_d    [NUM_MOTORS];
    logic [NUM_MOTORS-1:0] pwm_q, pwm_d;
    logic                  stale_q, frame_strt_q;
    logic                  wrap, zero_spd;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RUN;
        else        state_q <= state_d;
    end

    // Next-state, capture, frame-boundary load and pulse compare
    always_comb begin
        state_d   = state_q;
        wd_d      = wd_q;
        pending_d = pending_q;
        shadow_d  = shadow_q;
        active_d  = active_q;
        thr_d     = thr_q;
        pwm_d     = '0;
        zero_spd  = 1'b0;

        wrap  = (cnt_q == CNT_W'(PERIOD - 1));
        cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);

        for (int i = 0; i < NUM_MOTORS; i++) begin
            sat[i] = (32'(bus.spd[i*SPD_W +: SPD_W]) > MAX_SPD) ? SPD_W'(MAX_SPD)
                                                               : bus.spd[i*SPD_W +: SPD_W];
        end

        if (bus.wrt) begin
            shadow_d  = sat;
            pending_d = 1'b1;
            wd_d      = '0;
        end

        if (wrap) begin
            pending_d = 1'b0;
            if (!bus.wrt && wd_q != WD_W'(TIMEOUT_FRAMES)) wd_d = wd_q + WD_W'(1);
            case (state_q)
                RUN:      if (wd_d == WD_W'(TIMEOUT_FRAMES)) state_d = FAILSAFE;
                FAILSAFE: if (pending_q || bus.wrt) state_d = RUN;
            endcase
        end

        zero_spd = bus.motors_off || (state_d == FAILSAFE);

        // A coincident wrt already sits in shadow_d, which gives the bypass load for free
        for (int i = 0; i < NUM_MOTORS; i++) begin
            tgt[i] = zero_spd ? '0 : shadow_d[i];
            if (wrap) begin
`ifdef ESC_RAMP_EN
                if (zero_spd ||
                    ((tgt[i] >= active_q[i]) ? 32'(tgt[i] - active_q[i])
                                             : 32'(active_q[i] - tgt[i])) <= RAMP_STEP)
                    active_d[i] = tgt[i];
                else if (tgt[i] > active_q[i])
                    active_d[i] = active_q[i] + SPD_W'(RAMP_STEP);
                else
                    active_d[i] = active_q[i] - SPD_W'(RAMP_STEP);
`else
                active_d[i] = tgt[i];
`endif
                thr_d[i] = CNT_W'(MIN_PULSE + 32'(active_d[i]) * SCALE);
            end
            pwm_d[i] = (cnt_q < thr_q[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            wd_q         <= '0;
            pending_q    <= 1'b0;
            pwm_q        <= '0;
            stale_q      <= 1'b0;
            frame_strt_q <= 1'b0;
            for (int i = 0; i < NUM_MOTORS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
                thr_q[i]    <= CNT_W'(MIN_PULSE);
            end
        end else begin
            cnt_q        <= cnt_d;
            wd_q         <= wd_d;
            pending_q    <= pending_d;
            pwm_q        <= pwm_d;
            stale_q      <= (state_d == FAILSAFE);
            frame_strt_q <= wrap;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            thr_q        <= thr_d;
        end
    end

    assign bus.pwm        = pwm_q;
    assign bus.stale      = stale_q;
    assign bus.frame_strt = frame_strt_q;
endmodule
